// File: rtl/ccff_bitstream_loader.sv
// Configuration-chain loader: serialises DATA_W-bit words MSB-first into ccff_head,
// exactly CHAIN_LEN enabled shifts per session, folding ccff_tail into a parity bit.
module ccff_bitstream_loader #(
   parameter int CHAIN_LEN = 1024,
   parameter int DATA_W    = 8,
   parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              pReset_n,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              ccff_head,
   output logic              config_enable,
   input  logic              ccff_tail,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  bit_count,
   output logic              tail_parity
);

   localparam int SC_W = $clog2(DATA_W + 1);
   localparam logic [31:0] LEN32 = CHAIN_LEN;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [DATA_W-1:0] sh_data;
   logic [SC_W-1:0]   sh_cnt;
   logic [DATA_W-1:0] hold_data;
   logic              hold_full;
   logic [31:0]       queued;
   logic              accept;
   logic              issue;
   logic              issue_bit;
   logic              last_bit;
   logic              at_end;
   logic              begin_session;

   always_ff @(posedge prog_clk) begin
      if (!pReset_n) state <= IDLE;
      else           state <= state_nxt;
   end

   // DONE is entered one cycle after the final bit becomes visible, so busy
   // stays high while that last bit is on ccff_head.
   always_comb begin
      state_nxt     = state;
      queued        = 32'(bit_count) + 32'(sh_cnt) + (hold_full ? 32'(DATA_W) : 32'd0);
      at_end        = (32'(bit_count) == LEN32);
      s_ready       = (state == SHIFT) && !hold_full && (queued < LEN32);
      accept        = s_valid && s_ready;
      issue         = (state == SHIFT) && !abort && !at_end && ((sh_cnt != '0) || accept);
      issue_bit     = (sh_cnt != '0) ? sh_data[DATA_W-1] : s_data[DATA_W-1];
      last_bit      = issue && (32'(bit_count) + 32'd1 == LEN32);
      begin_session = start && !abort && ((state == IDLE) || (state == DONE));
      busy          = (state == SHIFT);
      done          = (state == DONE);
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE, DONE: if (start)  state_nxt = SHIFT;
            SHIFT:      if (at_end) state_nxt = DONE;
            default:                state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge prog_clk) begin
      if (!pReset_n) begin
         ccff_head     <= 1'b0;
         config_enable <= 1'b0;
         bit_count     <= '0;
         tail_parity   <= 1'b0;
         sh_data       <= '0;
         sh_cnt        <= '0;
         hold_data     <= '0;
         hold_full     <= 1'b0;
      end else begin
         config_enable <= issue;
         ccff_head     <= issue & issue_bit;

         if (begin_session) begin
            bit_count   <= '0;
            tail_parity <= 1'b0;
         end else begin
            if (issue)         bit_count   <= bit_count + CNT_W'(1);
            if (config_enable) tail_parity <= tail_parity ^ ccff_tail;
         end

         // An empty shifter lets an accepted word issue its MSB on the accept
         // edge; the rest of the word is kept in the shifter.
         if (begin_session || abort || last_bit) begin
            sh_data   <= '0;
            sh_cnt    <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
         end else if (issue) begin
            if (sh_cnt == '0) begin
               sh_data <= {s_data[DATA_W-2:0], 1'b0};
               sh_cnt  <= SC_W'(DATA_W - 1);
            end else if (sh_cnt == SC_W'(1)) begin
               if (hold_full) begin
                  sh_data   <= hold_data;
                  sh_cnt    <= SC_W'(DATA_W);
                  hold_full <= 1'b0;
               end else if (accept) begin
                  sh_data <= s_data;
                  sh_cnt  <= SC_W'(DATA_W);
               end else begin
                  sh_cnt <= '0;
               end
            end else begin
               sh_data <= {sh_data[DATA_W-2:0], 1'b0};
               sh_cnt  <= sh_cnt - SC_W'(1);
               if (accept) begin
                  hold_data <= s_data;
                  hold_full <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader: scoreboard of expected chain bits, two chain lengths.
module tb_ccff_bitstream_loader;

   localparam int DW = 8;

   logic        prog_clk = 1'b0;
   logic        pReset_n, start16, start20, abort, s_valid, preload, tail20, sel;
   logic [7:0]  s_data;
   logic        rdy16, head16, ce16, busy16, done16, par16;
   logic        rdy20, head20, ce20, busy20, done20, par20;
   logic [4:0]  cnt16, cnt20;
   logic [15:0] chain;
   logic        tail16;
   logic        act_ready, act_head, act_ce, act_busy, act_done, act_par;
   logic [4:0]  act_cnt;

   int cyc = 0;
   int n_vec = 0;
   int n_miss = 0;
   bit q[$];
   bit exp_b;
   int pushed, ce_cnt, acc_cnt, first_ce, last_ce;

   always #5 prog_clk = ~prog_clk;
   always @(posedge prog_clk) cyc <= cyc + 1;

   // 16-bit model of the configuration chain behind the 16-bit loader
   always @(posedge prog_clk) begin
      if (preload)   chain <= 16'h0007;
      else if (ce16) chain <= {chain[14:0], head16};
   end
   assign tail16 = chain[15];

   assign act_ready = sel ? rdy20  : rdy16;
   assign act_head  = sel ? head20 : head16;
   assign act_ce    = sel ? ce20   : ce16;
   assign act_busy  = sel ? busy20 : busy16;
   assign act_done  = sel ? done20 : done16;
   assign act_par   = sel ? par20  : par16;
   assign act_cnt   = sel ? cnt20  : cnt16;

   ccff_bitstream_loader #(.CHAIN_LEN(16), .DATA_W(DW)) u16 (
      .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start16), .abort(abort),
      .s_data(s_data), .s_valid(s_valid), .s_ready(rdy16), .ccff_head(head16),
      .config_enable(ce16), .ccff_tail(tail16), .busy(busy16), .done(done16),
      .bit_count(cnt16), .tail_parity(par16));

   ccff_bitstream_loader #(.CHAIN_LEN(20), .DATA_W(DW)) u20 (
      .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start20), .abort(abort),
      .s_data(s_data), .s_valid(s_valid), .s_ready(rdy20), .ccff_head(head20),
      .config_enable(ce20), .ccff_tail(tail20), .busy(busy20), .done(done20),
      .bit_count(cnt20), .tail_parity(par20));

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge prog_clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      if (sel) start20 = 1'b1;
      else     start16 = 1'b1;
      tick(1);
      start16 = 1'b0;
      start20 = 1'b0;
   endtask

   // Leaves s_valid high so back-to-back words can follow.
   task automatic send_word(input logic [7:0] w);
      int t;
      t = 0;
      s_data  = w;
      s_valid = 1'b1;
      while (!act_ready && t < 40) begin
         tick(1);
         t++;
      end
      if (!act_ready) check_val("ready_timeout", 32'(act_ready), 32'd1);
      else            tick(1);
   endtask

   task automatic wait_done();
      int t;
      t = 0;
      while (!act_done && t < 200) begin
         tick(1);
         t++;
      end
      check_val("done_seen", 32'(act_done), 32'd1);
   endtask

   // Scoreboard: accepted words push their usable bits, enabled cycles pop them.
   initial begin
      pushed = 0; ce_cnt = 0; acc_cnt = 0; first_ce = -1; last_ce = -1;
      forever begin
         @(negedge prog_clk);
         if (act_ce) begin
            ce_cnt++;
            if (first_ce < 0) first_ce = cyc;
            last_ce = cyc;
            if (q.size() == 0) begin
               check_val("extra_enable", 32'd1, 32'd0);
            end else begin
               exp_b = q.pop_front();
               check_val("head_bit", 32'(act_head), 32'(exp_b));
            end
         end
         if (abort || !pReset_n) begin
            q.delete();
         end else if (start16 || start20) begin
            q.delete();
            pushed = 0; ce_cnt = 0; acc_cnt = 0; first_ce = -1; last_ce = -1;
         end else if (s_valid && act_ready) begin
            acc_cnt++;
            for (int i = DW - 1; i >= 0; i--) begin
               if (pushed < (sel ? 20 : 16)) begin
                  q.push_back(s_data[i]);
                  pushed++;
               end
            end
         end
      end
   end

   initial begin
      sel = 1'b0; pReset_n = 1'b0; start16 = 1'b1; start20 = 1'b1; abort = 1'b0;
      s_valid = 1'b1; s_data = 8'hA5; preload = 1'b0; tail20 = 1'b0;

      for (int i = 0; i < 3; i++) begin
         tick(1);
         check_val("rst16", 32'({rdy16, head16, ce16, busy16, done16, par16, cnt16}), 32'd0);
         check_val("rst20", 32'({rdy20, head20, ce20, busy20, done20, par20, cnt20}), 32'd0);
      end
      pReset_n = 1'b1; start16 = 1'b0; start20 = 1'b0; s_valid = 1'b0;
      tick(2);
      check_val("idle_after_rst", 32'({busy16, done16, rdy16, ce16}), 32'd0);

      // back-to-back words with s_valid held high
      preload = 1'b1; tick(1); preload = 1'b0;
      s_data = 8'hA5; s_valid = 1'b1;
      pulse_start();
      check_val("start_shift", 32'({act_busy, act_ready}), 32'd3);
      send_word(8'hA5);
      check_val("first_bit", 32'({act_ce, act_head}), 32'd3);
      check_val("first_cnt", 32'(act_cnt), 32'd1);
      send_word(8'h3C);
      for (int i = 0; i < 3; i++) begin
         check_val("ready_low", 32'(act_ready), 32'd0);
         tick(1);
      end
      wait_done();
      check_val("done_latency", 32'(cyc - last_ce), 32'd1);
      check_val("no_gap", 32'(last_ce - first_ce + 1), 32'd16);
      check_val("ce_cnt_a", 32'(ce_cnt), 32'd16);
      check_val("bit_count_a", 32'(act_cnt), 32'd16);
      check_val("accepts_a", 32'(acc_cnt), 32'd2);
      check_val("parity_a", 32'(act_par), 32'd1);
      check_val("chain_a", 32'(chain), 32'h0000A53C);
      check_val("busy_after_done", 32'({act_busy, act_ready}), 32'd0);
      check_val("sb_empty_a", 32'(q.size()), 32'd0);
      s_valid = 1'b0;

      // stall between words
      pulse_start();
      send_word(8'h5A);
      s_valid = 1'b0;
      tick(8);
      for (int i = 0; i < 5; i++) begin
         check_val("stall_ce", 32'(act_ce), 32'd0);
         check_val("stall_cnt", 32'(act_cnt), 32'd8);
         tick(1);
      end
      send_word(8'hC3);
      s_valid = 1'b0;
      wait_done();
      check_val("ce_cnt_s", 32'(ce_cnt), 32'd16);
      check_val("bit_count_s", 32'(act_cnt), 32'd16);
      check_val("chain_s", 32'(chain), 32'h00005AC3);
      check_val("sb_empty_s", 32'(q.size()), 32'd0);

      // abort after five bits, then a clean session
      pulse_start();
      send_word(8'h96);
      s_valid = 1'b0;
      tick(4);
      check_val("pre_abort_cnt", 32'(act_cnt), 32'd5);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check_val("abort_state", 32'({act_ce, act_busy, act_done}), 32'd0);
      check_val("abort_cnt", 32'(act_cnt), 32'd5);
      tick(2);
      check_val("abort_hold", 32'({act_ce, act_busy, act_cnt}), 32'd5);
      preload = 1'b1; tick(1); preload = 1'b0;
      pulse_start();
      send_word(8'h3C);
      send_word(8'hA5);
      s_valid = 1'b0;
      wait_done();
      check_val("ce_cnt_r", 32'(ce_cnt), 32'd16);
      check_val("bit_count_r", 32'(act_cnt), 32'd16);
      check_val("chain_r", 32'(chain), 32'h00003CA5);
      check_val("parity_r", 32'(act_par), 32'd1);

      // 20-bit chain: partial final word, fourth word refused
      sel = 1'b1;
      pulse_start();
      send_word(8'hFF);
      send_word(8'h00);
      send_word(8'hF0);
      s_data = 8'hAA;
      wait_done();
      tick(3);
      s_valid = 1'b0;
      check_val("accepts_20", 32'(acc_cnt), 32'd3);
      check_val("ce_cnt_20", 32'(ce_cnt), 32'd20);
      check_val("bit_count_20", 32'(act_cnt), 32'd20);
      check_val("ready_20", 32'(act_ready), 32'd0);
      check_val("sb_empty_20", 32'(q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
